// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port RAM with a fixed
// read latency. One transaction at a time: grant, one-cycle RAM access, wait, one-cycle response.
module mem_arbiter #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_ren,
    output logic        ram_wen,
    input  logic [31:0] ram_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

    localparam logic [2:0] CntLoad = 3'(LATENCY - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;  // 1: data port was granted last
    logic        sel_data_q, sel_data_d;
    logic        store_q, store_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic        ram_ren_q, ram_ren_d;
    logic        ram_wen_q, ram_wen_d;
    logic        i_ready_q, i_ready_d;
    logic        d_ready_q, d_ready_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        busy_q, busy_d;

    logic data_req;
    logic pick_data;
    logic pick_store;

    assign data_req   = d_read | d_write;
    assign pick_data  = data_req & (~i_req | ~last_grant_q);
    // A simultaneous read and write is a store.
    assign pick_store = pick_data & d_write;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        sel_data_d   = sel_data_q;
        store_d      = store_q;
        ram_addr_d   = '0;
        ram_wdata_d  = '0;
        ram_ren_d    = 1'b0;
        ram_wen_d    = 1'b0;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (i_req || data_req) begin
                    state_d      = StAccess;
                    sel_data_d   = pick_data;
                    store_d      = pick_store;
                    last_grant_d = pick_data;
                    ram_addr_d   = pick_data ? d_addr : i_addr;
                    ram_wdata_d  = pick_store ? d_wdata : '0;
                    ram_ren_d    = ~pick_store;
                    ram_wen_d    = pick_store;
                end
            end
            StAccess: begin
                state_d = StWait;
                cnt_d   = CntLoad;
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    state_d = StResp;
                    if (sel_data_q) begin
                        d_ready_d = 1'b1;
                        if (!store_q) d_rdata_d = ram_rdata;
                    end else begin
                        i_ready_d = 1'b1;
                        i_rdata_d = ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            last_grant_q <= 1'b1;
            sel_data_q   <= 1'b0;
            store_q      <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_ren_q    <= 1'b0;
            ram_wen_q    <= 1'b0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            sel_data_q   <= sel_data_d;
            store_q      <= store_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_ren_q    <= ram_ren_d;
            ram_wen_q    <= ram_wen_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_ren   = ram_ren_q;
    assign ram_wen   = ram_wen_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at LATENCY=2 with a two-stage pipelined RAM model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_read, d_write;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ready, d_ready, ram_ren, ram_wen, busy;
    logic [31:0] i_rdata, d_rdata, ram_addr, ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic [31:0] rd_p1 = 32'h0;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.LATENCY(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ready  (i_ready),
        .i_rdata  (i_rdata),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rdata  (d_rdata),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_ren  (ram_ren),
        .ram_wen  (ram_wen),
        .ram_rdata(ram_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h3E800093;
            32'h14:  return 32'h00A00513;
            32'h200: return 32'h12345678;
            32'h300: return 32'hCAFEF00D;
            default: return 32'h0BAD0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    // Read sampled at edge N appears on ram_rdata after edge N+1, stable for edge N+2.
    always @(posedge clk) begin
        rd_p1     <= ram_ren ? ram_word(ram_addr) : 32'h0;
        ram_rdata <= rd_p1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        i_req, d_read, d_write;
        logic [31:0] i_addr, d_addr, d_wdata;
        logic        exp_data, exp_ren, exp_wen;
        logic [31:0] exp_addr, exp_wdata, exp_i, exp_d;
    } vec_t;

    vec_t vecs[5];

    // Starts at a negedge with the arbiter idle; ends at the negedge after the return to idle.
    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        i_req = v.i_req; i_addr = v.i_addr;
        d_read = v.d_read; d_write = v.d_write; d_addr = v.d_addr; d_wdata = v.d_wdata;
        @(negedge clk);
        chk({t, "_access_ren"}, {31'h0, ram_ren}, {31'h0, v.exp_ren});
        chk({t, "_access_wen"}, {31'h0, ram_wen}, {31'h0, v.exp_wen});
        chk({t, "_access_addr"}, ram_addr, v.exp_addr);
        chk({t, "_access_wdata"}, ram_wdata, v.exp_wdata);
        chk({t, "_access_busy"}, {31'h0, busy}, 32'h1);
        @(negedge clk);
        chk({t, "_wait_strobes"}, {30'h0, ram_ren, ram_wen}, 32'h0);
        @(negedge clk);
        chk({t, "_wait_ready"}, {30'h0, i_ready, d_ready}, 32'h0);
        @(negedge clk);
        chk({t, "_resp_ready"}, {30'h0, i_ready, d_ready}, v.exp_data ? 32'h1 : 32'h2);
        chk({t, "_i_rdata"}, i_rdata, v.exp_i);
        chk({t, "_d_rdata"}, d_rdata, v.exp_d);
        i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
        @(negedge clk);
        chk({t, "_done_ready"}, {30'h0, i_ready, d_ready}, 32'h0);
        chk({t, "_done_busy"}, {31'h0, busy}, 32'h0);
    endtask

    // Fetch 0x10 and load 0x200 raised together; the loser must follow five cycles later.
    task automatic tie(input logic exp_data_first, input string t);
        int ti = -1;
        int di = -1;
        logic both = 1'b0;
        i_req = 1'b1; i_addr = 32'h10;
        d_read = 1'b1; d_write = 1'b0; d_addr = 32'h200; d_wdata = 32'h0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (i_ready && d_ready) both = 1'b1;
            if (i_ready && ti < 0) begin
                ti = cyc;
                chk({t, "_i_rdata"}, i_rdata, 32'h3E800093);
                i_req = 1'b0;
            end
            if (d_ready && di < 0) begin
                di = cyc;
                chk({t, "_d_rdata"}, d_rdata, 32'h12345678);
                d_read = 1'b0;
            end
            if (ti >= 0 && di >= 0) break;
        end
        i_req = 1'b0; d_read = 1'b0;
        chk({t, "_both_served"}, {30'h0, ti >= 0, di >= 0}, 32'h3);
        chk({t, "_data_first"}, {31'h0, di < ti}, {31'h0, exp_data_first});
        chk({t, "_gap"}, exp_data_first ? 32'(ti - di) : 32'(di - ti), 32'd5);
        chk({t, "_never_both"}, {31'h0, both}, 32'h0);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string t);
        chk({t, "_ready"}, {30'h0, i_ready, d_ready}, 32'h0);
        chk({t, "_i_rdata"}, i_rdata, 32'h0);
        chk({t, "_d_rdata"}, d_rdata, 32'h0);
        chk({t, "_ram_addr"}, ram_addr, 32'h0);
        chk({t, "_ram_wdata"}, ram_wdata, 32'h0);
        chk({t, "_strobes_busy"}, {29'h0, ram_ren, ram_wen, busy}, 32'h0);
    endtask

    initial begin
        int seen;
        vec_t v;
        rst = 1'b1;
        i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;

        //           req rd wr  i_addr        d_addr        d_wdata       dat ren wen addr          wdata         exp_i         exp_d
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h14, 32'h0, 32'h55555555, 1'b0, 1'b1, 1'b0,
                    32'h14, 32'h0, 32'h00A00513, 32'h12345678};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'h55555555, 1'b1, 1'b1, 1'b0,
                    32'h300, 32'h0, 32'h00A00513, 32'hCAFEF00D};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1,
                    32'h100, 32'hDEADBEEF, 32'h00A00513, 32'hCAFEF00D};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h14, 32'h11223344, 1'b1, 1'b0, 1'b1,
                    32'h14, 32'h11223344, 32'h00A00513, 32'hCAFEF00D};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0,
                    32'h10, 32'h0, 32'h3E800093, 32'hCAFEF00D};

        repeat (3) @(negedge clk);
        chk_all_zero("in_reset");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("after_reset");

        tie(1'b0, "tie_first");
        for (int k = 0; k < 5; k++) run_vec(vecs[k], k);
        tie(1'b1, "tie_alt");

        // Reset in the WAIT state of a fetch, during clock-low.
        i_req = 1'b1; i_addr = 32'h300;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        i_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (i_ready || d_ready) seen++;
        end
        chk("dropped_no_ready", 32'(seen), 32'h0);

        v = '{1'b1, 1'b0, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0,
              32'h14, 32'h0, 32'h00A00513, 32'h0};
        run_vec(v, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 2, RAM read latency in cycles; legal range 1..7.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 i_req  input  1  instruction-fetch request; held until i_ready is seen.
REQ-005 i_addr  input  32  fetch byte address.
REQ-006 i_ready  output  1  one-cycle pulse; i_rdata valid while high.
REQ-007 i_rdata  output  32  fetched instruction word.
REQ-008 d_read  input  1  data-load request; held until d_ready is seen.
REQ-009 d_write  input  1  data-store request; held until d_ready is seen.
REQ-010 d_addr  input  32  data byte address.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_ready  output  1  one-cycle completion pulse for a load or store.
REQ-013 d_rdata  output  32  load data.
REQ-014 ram_addr  output  32  shared single-port RAM address.
REQ-015 ram_wdata  output  32  RAM write data.
REQ-016 ram_ren  output  1  RAM read strobe.
REQ-017 ram_wen  output  1  RAM write strobe.
REQ-018 ram_rdata  input  32  RAM read data; valid at the LATENCY-th rising edge after the edge that first samples ram_ren high.
REQ-019 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, ACCESS, WAIT and RESP.
REQ-021 IDLE -> ACCESS at an edge sampling any request; otherwise it SHALL stay in IDLE.
REQ-022 At the IDLE->ACCESS edge the block SHALL latch the winning port, its address and its store data; later changes to port inputs SHALL be ignored until IDLE is re-entered.
REQ-023 Arbitration: a single pending port SHALL win; if fetch and data are both pending, the port not granted last SHALL win (last_grant flop).
REQ-024 d_read and d_write both high SHALL be treated as a store; the read SHALL be ignored.
REQ-025 In ACCESS, for exactly one cycle, the block SHALL drive ram_addr, and also ram_wdata for stores, and SHALL assert ram_ren (fetch/load) or ram_wen (store), never both.
REQ-026 ACCESS -> WAIT unconditionally; a 3-bit counter SHALL load LATENCY-1.
REQ-027 WAIT SHALL decrement the counter each cycle and go to RESP at the edge where the counter is 0; that edge is E0+LATENCY+1, where E0 is the grant edge.
REQ-028 At the WAIT->RESP edge, fetch or load data SHALL be captured from ram_rdata into i_rdata or d_rdata respectively.
REQ-029 Stores SHALL use the same ACCESS/WAIT/RESP timing; d_rdata SHALL be unchanged by a store.
REQ-030 In RESP, i_ready or d_ready (matching the granted port) SHALL be high for exactly one cycle; requests SHALL be ignored in RESP.
REQ-031 RESP -> IDLE unconditionally; the transaction period SHALL be LATENCY+3 cycles from grant edge to next possible grant edge.
REQ-032 ram_addr, ram_wdata, ram_ren and ram_wen SHALL be 0 outside ACCESS.
REQ-033 i_rdata and d_rdata SHALL hold their last captured value until the next capture of the same port.
REQ-034 i_ready and d_ready SHALL never be high in the same cycle.

Reset
REQ-035 rst high SHALL immediately force state IDLE, counter 0, last_grant = data (fetch wins the first tie), and all outputs, including i_rdata and d_rdata, to 0.
REQ-036 rst asserted mid-transaction SHALL drop the transaction with no ready pulse; service SHALL resume normally after release.

Verification (LATENCY=2, grant edge E0)
REQ-037 Assert rst during a clock-low phase -> all outputs read 0 before the next clk edge; busy=0.
REQ-038 i_req, i_addr=0x00000010, RAM returns 0x3E800093 -> ram_ren=1 for one cycle E0..E1 with ram_addr=0x10; i_ready=1 for E3..E4 with i_rdata=0x3E800093; busy=0 after E4.
REQ-039 i_req and d_read (d_addr=0x200) rise together after reset -> fetch is served first; d_ready pulses exactly 5 cycles after i_ready; d_rdata = RAM word at 0x200.
REQ-040 d_write, d_addr=0x100, d_wdata=0xDEADBEEF -> ram_wen=1 for one cycle with ram_addr=0x100 and ram_wdata=0xDEADBEEF; ram_ren=0; d_ready at E3..E4; d_rdata unchanged.
REQ-041 d_read and d_write both high -> ram_wen only, no ram_ren. rst pulsed during WAIT of a fetch -> no i_ready. A re-issued fetch after release completes with the correct data.
